// File: rtl/bch_chien_correct.sv
// Serial Chien search and bit correction for the BCH(15,k) decoder over GF(16)
// with primitive polynomial x^4+x+1.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   job handshake carrying l1, l2 and codeword
//   l1, l2              locator coefficients, sigma(x) = 1 + l1*x + l2*x^2
//   codeword            received word, bit k is the coefficient of x^k
//   out_valid/out_ready result handshake
//   corrected           codeword XOR err_mask
//   err_mask            located error positions
//   err_count           number of corrected bits (0..2)
//   fail                uncorrectable pattern detected
// Optional feature macro: BCH_CHIEN_EARLY_EXIT_EN (skip or cut the search once
// all expected roots are found).
module bch_chien_correct #(
  parameter int unsigned N = 15,
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] l1,
  input  logic [M-1:0] l2,
  input  logic [N-1:0] codeword,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] corrected,
  output logic [N-1:0] err_mask,
  output logic [1:0]   err_count,
  output logic         fail
);

  localparam int unsigned KW = 4;

  if (N != 15 || M != 4) begin : g_param_check
    $error("bch_chien_correct supports only N=15 and M=4");
  end

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

  // Multiply by alpha^14 = alpha^-1 in GF(16), x^4+x+1.
  function automatic logic [M-1:0] mul_inv(input logic [M-1:0] v);
    return {v[0], v[3], v[2], v[1] ^ v[0]};
  endfunction

  function automatic logic [1:0] deg_of(input logic [M-1:0] a, input logic [M-1:0] b);
    if (b != '0)      return 2'd2;
    else if (a != '0) return 2'd1;
    else              return 2'd0;
  endfunction

  state_e         state_q, state_d;
  logic [M-1:0]   r1_q, r1_d, r2_q, r2_d;
  logic [KW-1:0]  k_q, k_d;
  logic [N-1:0]   mask_q, mask_d, cw_q, cw_d;
  logic [1:0]     roots_q, roots_d, deg_q, deg_d;
  logic           in_ready_q, in_ready_d, out_valid_q, out_valid_d, fail_q, fail_d;
  logic [N-1:0]   corrected_q, corrected_d, err_mask_q, err_mask_d;
  logic [1:0]     err_count_q, err_count_d;

  logic           root_c;
  logic           finish_c;
  logic [N-1:0]   mask_nx_c;
  logic [1:0]     roots_nx_c;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    k_d         = k_q;
    mask_d      = mask_q;
    cw_d        = cw_q;
    roots_d     = roots_q;
    deg_d       = deg_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    fail_d      = fail_q;
    corrected_d = corrected_q;
    err_mask_d  = err_mask_q;
    err_count_d = err_count_q;

    // sigma(alpha^-k) = 1 ^ r1 ^ r2 at the current position.
    root_c     = ((r1_q ^ r2_q) == M'(1));
    mask_nx_c  = mask_q | (N'(root_c) << k_q);
    roots_nx_c = (root_c && roots_q != 2'd3) ? roots_q + 2'd1 : roots_q;
    finish_c   = (k_q == KW'(N - 1));
`ifdef BCH_CHIEN_EARLY_EXIT_EN
    finish_c   = finish_c || (roots_nx_c == deg_q);
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          r1_d       = l1;
          r2_d       = l2;
          k_d        = '0;
          mask_d     = '0;
          roots_d    = '0;
          cw_d       = codeword;
          deg_d      = deg_of(l1, l2);
          in_ready_d = 1'b0;
          state_d    = SEARCH;
`ifdef BCH_CHIEN_EARLY_EXIT_EN
          if (deg_of(l1, l2) == 2'd0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            fail_d      = 1'b0;
            err_mask_d  = '0;
            err_count_d = 2'd0;
            corrected_d = codeword;
          end
`endif
        end
      end
      SEARCH: begin
        r1_d    = mul_inv(r1_q);
        r2_d    = mul_inv(mul_inv(r2_q));
        k_d     = k_q + KW'(1);
        mask_d  = mask_nx_c;
        roots_d = roots_nx_c;
        if (finish_c) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (roots_nx_c == deg_q) begin
            fail_d      = 1'b0;
            err_mask_d  = mask_nx_c;
            err_count_d = roots_nx_c;
            corrected_d = cw_q ^ mask_nx_c;
          end else begin
            fail_d      = 1'b1;
            err_mask_d  = '0;
            err_count_d = 2'd0;
            corrected_d = cw_q;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      r1_q        <= '0;
      r2_q        <= '0;
      k_q         <= '0;
      mask_q      <= '0;
      cw_q        <= '0;
      roots_q     <= '0;
      deg_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fail_q      <= 1'b0;
      corrected_q <= '0;
      err_mask_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      k_q         <= k_d;
      mask_q      <= mask_d;
      cw_q        <= cw_d;
      roots_q     <= roots_d;
      deg_q       <= deg_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fail_q      <= fail_d;
      corrected_q <= corrected_d;
      err_mask_q  <= err_mask_d;
      err_count_q <= err_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign corrected = corrected_q;
  assign err_mask  = err_mask_q;
  assign err_count = err_count_q;
  assign fail      = fail_q;

endmodule
